// File: rtl/seq_div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_e;

  // Counter must hold the value A_W itself, hence the +1.
  function automatic int cnt_width(input int a_w);
    return $clog2(a_w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle between a requester and the divider.
interface seq_divider_if #(
  parameter int A_W = 128,
  parameter int B_W = 64
);

  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] dividend;
  logic [B_W-1:0] divisor;
  logic           out_valid;
  logic           out_ready;
  logic [A_W-1:0] quotient;
  logic [B_W-1:0] remainder;
  logic           div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration: shift in the next
// dividend bit, trial-subtract the divisor, keep the difference if it fits.
module div_step #(
  parameter int B_W = 64
) (
  input  logic [B_W:0]   rem,
  input  logic           q_msb,
  input  logic [B_W-1:0] divisor,
  output logic [B_W:0]   rem_next,
  output logic           q_bit
);

  logic [B_W:0] shifted;
  logic [B_W:0] diff;
  logic         unused_rem_msb;

  // After a restoring step the remainder is below the divisor, so its top bit is always 0.
  assign unused_rem_msb = rem[B_W];

  always_comb begin
    shifted  = {rem[B_W-1:0], q_msb};
    diff     = shifted - {1'b0, divisor};
    q_bit    = (shifted >= {1'b0, divisor});
    rem_next = q_bit ? diff : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock,
// with valid/ready handshakes on the operand and result sides.
module seq_divider #(
  parameter int A_W = 128,
  parameter int B_W = 64
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  import seq_div_pkg::*;

  localparam int CNT_W = cnt_width(A_W);

  div_state_e     state_q, state_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic [A_W-1:0] q_q, q_d;
  logic [B_W-1:0] dvsr_q, dvsr_d;
  logic [B_W:0]   rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [A_W-1:0] quotient_q, quotient_d;
  logic [B_W-1:0] remainder_q, remainder_d;
  logic           dbz_q, dbz_d;

  logic [B_W:0]   step_rem;
  logic           step_bit;
  logic [A_W-1:0] q_shifted;

  div_step #(.B_W(B_W)) u_step (
    .rem      (rem_q),
    .q_msb    (q_q[A_W-1]),
    .divisor  (dvsr_q),
    .rem_next (step_rem),
    .q_bit    (step_bit)
  );

  // The quotient shift register doubles as the dividend source; result
  // registers are separate so they only change when entering DONE.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    q_d         = q_q;
    dvsr_d      = dvsr_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    q_shifted   = {q_q[A_W-2:0], step_bit};

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          if (bus.divisor == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            quotient_d  = '1;
            remainder_d = bus.dividend[B_W-1:0];
            dbz_d       = 1'b1;
          end else begin
            state_d = BUSY;
            q_d     = bus.dividend;
            dvsr_d  = bus.divisor;
            rem_d   = '0;
            cnt_d   = CNT_W'(A_W);
          end
        end
      end
      BUSY: begin
        q_d   = q_shifted;
        rem_d = step_rem;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          quotient_d  = q_shifted;
          remainder_d = step_rem[B_W-1:0];
          dbz_d       = 1'b0;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      dvsr_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
      dvsr_q      <= dvsr_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: an arithmetic reference model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_seq_divider;

  localparam int A_W      = 128;
  localparam int B_W      = 64;
  localparam int MAX_WAIT = 300;

  logic clk = 1'b0;
  logic rst;

  seq_divider_if #(.A_W(A_W), .B_W(B_W)) bus ();

  seq_divider #(.A_W(A_W), .B_W(B_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string name, input logic [A_W-1:0] actual,
                           input logic [A_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: results come from plain / and %, timing from a countdown.
  bit             m_known = 1'b0;
  bit             m_ready;
  bit             m_valid;
  int             m_wait;
  logic [A_W-1:0] m_q, p_q;
  logic [B_W-1:0] m_r, p_r;
  bit             m_dbz, p_dbz;
  logic [A_W-1:0] m_wide_div, m_wide_rem;

  always @(posedge clk) begin
    if (rst) begin
      m_known = 1'b1;
      m_ready = 1'b1;
      m_valid = 1'b0;
      m_wait  = 0;
      m_q     = '0;
      m_r     = '0;
      m_dbz   = 1'b0;
    end else if (m_known) begin
      if (m_ready && bus.in_valid) begin
        m_ready = 1'b0;
        if (bus.divisor == '0) begin
          m_valid = 1'b1;
          m_q     = '1;
          m_r     = bus.dividend[B_W-1:0];
          m_dbz   = 1'b1;
        end else begin
          m_wide_div = {{(A_W-B_W){1'b0}}, bus.divisor};
          p_q        = bus.dividend / m_wide_div;
          m_wide_rem = bus.dividend % m_wide_div;
          p_r        = m_wide_rem[B_W-1:0];
          p_dbz      = 1'b0;
          m_wait     = A_W;
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1'b1;
          m_q     = p_q;
          m_r     = p_r;
          m_dbz   = p_dbz;
        end
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
        m_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check_val("cmp_in_ready",    A_W'(bus.in_ready),    A_W'(m_ready));
      check_val("cmp_out_valid",   A_W'(bus.out_valid),   A_W'(m_valid));
      check_val("cmp_quotient",    bus.quotient,          m_q);
      check_val("cmp_remainder",   A_W'(bus.remainder),   A_W'(m_r));
      check_val("cmp_div_by_zero", A_W'(bus.div_by_zero), A_W'(m_dbz));
    end
  end

  // Called at posedge+#1; waits (bounded) for in_ready, then presents operands for one edge.
  task automatic applyStimulus(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < MAX_WAIT) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("accept_ready", A_W'(bus.in_ready), A_W'(1));
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Edges after the accepting edge until out_valid is seen; returns at a negedge.
  task automatic waitResult(output int lat);
    lat = -1;
    for (int i = 0; i <= MAX_WAIT; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        lat = i;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic checkOutput(input string name, input logic [A_W-1:0] eq,
                             input logic [B_W-1:0] er, input bit edbz,
                             input int elat, input int lat);
    check_val({name, "_latency"},   A_W'(lat),             A_W'(elat));
    check_val({name, "_quotient"},  bus.quotient,          eq);
    check_val({name, "_remainder"}, A_W'(bus.remainder),   A_W'(er));
    check_val({name, "_dbz"},       A_W'(bus.div_by_zero), A_W'(edbz));
  endtask

  task automatic releaseResult();
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic runDivide(input string name, input logic [A_W-1:0] a,
                           input logic [B_W-1:0] b, input logic [A_W-1:0] eq,
                           input logic [B_W-1:0] er, input bit edbz, input int elat);
    int lat;
    applyStimulus(a, b);
    waitResult(lat);
    checkOutput(name, eq, er, edbz, elat, lat);
    releaseResult();
  endtask

  logic [A_W-1:0] product;
  int             lat;

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check_val("reset_in_ready",  A_W'(bus.in_ready),    A_W'(1));
    check_val("reset_out_valid", A_W'(bus.out_valid),   A_W'(0));
    check_val("reset_quotient",  bus.quotient,          '0);
    check_val("reset_remainder", A_W'(bus.remainder),   '0);
    check_val("reset_dbz",       A_W'(bus.div_by_zero), '0);
    @(posedge clk); #1;

    runDivide("div100by7", 128'd100, 64'd7, 128'd14, 64'd2, 1'b0, 128);
    runDivide("allones", '1, 64'hFFFF_FFFF_FFFF_FFFF,
              128'h1_0000_0000_0000_0001, 64'd0, 1'b0, 128);
    product = {64'd0, 64'h00FF_FFFF_FFFF_FFFF} * {64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    runDivide("inverse_mul", product, 64'hFFFF_FFFF_FFFF_FFFF,
              128'h00FF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 128);
    runDivide("div5by9", 128'd5, 64'd9, 128'd0, 64'd5, 1'b0, 128);
    runDivide("div_zero", 128'd12345, 64'd0, '1, 64'd12345, 1'b1, 0);
    runDivide("div_one", '1, 64'd1, '1, 64'd0, 1'b0, 128);
    runDivide("near_divisor", 128'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
              128'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 128);

    // Backpressure: result held while a stray request is offered and ignored.
    applyStimulus(128'd1000, 64'd3);
    waitResult(lat);
    checkOutput("bp", 128'd333, 64'd1, 1'b0, 128, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.dividend = 128'd77;
      bus.divisor  = 64'd5;
      bus.in_valid = 1'b1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_val("bp_hold_quotient",  bus.quotient,        128'd333);
    check_val("bp_hold_remainder", A_W'(bus.remainder), 128'd1);
    check_val("bp_hold_in_ready",  A_W'(bus.in_ready),  A_W'(0));
    releaseResult();
    @(negedge clk);
    check_val("bp_release_in_ready", A_W'(bus.in_ready), A_W'(1));
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of an operation discards it.
    applyStimulus(128'd100, 64'd7);
    repeat (49) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("midrst_in_ready",  A_W'(bus.in_ready),  A_W'(1));
    check_val("midrst_out_valid", A_W'(bus.out_valid), A_W'(0));
    @(posedge clk); #1;
    runDivide("after_rst", 128'd100, 64'd7, 128'd14, 64'd2, 1'b0, 128);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
